// File: rtl/crop_embed.sv
// crop_embed: re-embeds a cropped OUT_ROWS x OUT_COLS patch stream into a full
// IN_ROWS x IN_COLS raster frame. The patch lands at (crop_x0, crop_y0), which is
// clamped so the patch always fits. Every other pixel is FILL_VALUE.
//
// Ports:
//   clk, srst            clock and synchronous active-high reset
//   ap_start             start one frame (accepted only while idle)
//   ap_ready, ap_idle    high while idle
//   ap_done              one-cycle pulse after the last frame pixel handshakes
//   crop_x0, crop_y0     patch origin, latched at start
//   s_axis_*             patch pixel stream in raster order (tvalid/tready/tdata)
//   m_axis_*             frame pixel stream (tvalid/tready/tdata/tuser/tlast)
//   cnt_col, cnt_row     frame coordinates of the pixel currently on m_axis
module crop_embed #(
  parameter int unsigned PIXEL_BIT_WIDTH = 10,
  parameter int unsigned IN_ROWS         = 20,
  parameter int unsigned IN_COLS         = 20,
  parameter int unsigned OUT_ROWS        = 10,
  parameter int unsigned OUT_COLS        = 10,
  parameter int unsigned FILL_VALUE      = 0
) (
  input  logic                         clk,
  input  logic                         srst,
  input  logic                         ap_start,
  output logic                         ap_ready,
  output logic                         ap_idle,
  output logic                         ap_done,
  input  logic [$clog2(IN_COLS)-1:0]   crop_x0,
  input  logic [$clog2(IN_ROWS)-1:0]   crop_y0,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic [PIXEL_BIT_WIDTH-1:0]   s_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [PIXEL_BIT_WIDTH-1:0]   m_axis_tdata,
  output logic                         m_axis_tuser,
  output logic                         m_axis_tlast,
  output logic [$clog2(IN_COLS)-1:0]   cnt_col,
  output logic [$clog2(IN_ROWS)-1:0]   cnt_row
);

  localparam int unsigned PW    = PIXEL_BIT_WIDTH;
  localparam int unsigned CW    = $clog2(IN_COLS);
  localparam int unsigned RW    = $clog2(IN_ROWS);
  localparam int unsigned MAXD  = (IN_ROWS > IN_COLS) ? IN_ROWS : IN_COLS;
  // One extra bit so x0+OUT_COLS / y0+OUT_ROWS cannot overflow in the window test.
  localparam int unsigned XW    = $clog2(MAXD) + 1;
  localparam int unsigned X_MAX = IN_COLS - OUT_COLS;
  localparam int unsigned Y_MAX = IN_ROWS - OUT_ROWS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   x0, x0_n;
  logic [RW-1:0]   y0, y0_n;
  logic [CW-1:0]   gc, gc_n;
  logic [RW-1:0]   gr, gr_n;
  logic            idle_q, idle_n;
  logic            done_n;
  logic            tvalid_n, tuser_n, tlast_n;
  logic [PW-1:0]   tdata_n;
  logic [CW-1:0]   ccol_n;
  logic [RW-1:0]   crow_n;
  logic            load_en_c;
  logic            in_win_c;
  logic            s_ready_c;
  logic [XW-1:0]   gc_w, gr_w, x0_w, y0_w;

  // Widened copies for the window compare.
  assign gc_w = XW'(gc);
  assign gr_w = XW'(gr);
  assign x0_w = XW'(x0);
  assign y0_w = XW'(y0);

  // Output register may take a new pixel when empty or being drained this cycle.
  assign load_en_c = !m_axis_tvalid || m_axis_tready;

  assign in_win_c = (gc_w >= x0_w) && (gc_w < (x0_w + XW'(OUT_COLS))) &&
                    (gr_w >= y0_w) && (gr_w < (y0_w + XW'(OUT_ROWS)));

  assign s_axis_tready = s_ready_c;
  assign ap_ready      = idle_q;
  assign ap_idle       = idle_q;

  // Next-state, counter and output-register logic.
  always_comb begin
    state_n   = state;
    x0_n      = x0;
    y0_n      = y0;
    gc_n      = gc;
    gr_n      = gr;
    done_n    = 1'b0;
    tvalid_n  = m_axis_tvalid;
    tdata_n   = m_axis_tdata;
    tuser_n   = m_axis_tuser;
    tlast_n   = m_axis_tlast;
    ccol_n    = cnt_col;
    crow_n    = cnt_row;
    s_ready_c = 1'b0;

    case (state)
      S_IDLE: begin
        if (ap_start) begin
          // Clamp the origin so the patch never wraps or truncates.
          x0_n    = (XW'(crop_x0) > XW'(X_MAX)) ? CW'(X_MAX) : crop_x0;
          y0_n    = (XW'(crop_y0) > XW'(Y_MAX)) ? RW'(Y_MAX) : crop_y0;
          gc_n    = '0;
          gr_n    = '0;
          state_n = S_RUN;
        end
      end

      S_RUN: begin
        // srst outranks any handshake, so never advertise ready while it is high.
        s_ready_c = in_win_c && load_en_c && !srst;
        if (m_axis_tready) begin
          tvalid_n = 1'b0;
        end
        // Inside the window a missing patch pixel stalls; outside, fill is always ready.
        if (load_en_c && (!in_win_c || s_axis_tvalid)) begin
          tvalid_n = 1'b1;
          tdata_n  = in_win_c ? s_axis_tdata : PW'(FILL_VALUE);
          tuser_n  = (gr == '0) && (gc == '0);
          tlast_n  = (gc == CW'(IN_COLS - 1));
          ccol_n   = gc;
          crow_n   = gr;
          if (gc == CW'(IN_COLS - 1)) begin
            gc_n = '0;
            if (gr == RW'(IN_ROWS - 1)) begin
              gr_n    = '0;
              state_n = S_DRAIN;
            end else begin
              gr_n = gr + RW'(1);
            end
          end else begin
            gc_n = gc + CW'(1);
          end
        end
      end

      S_DRAIN: begin
        if (m_axis_tvalid && m_axis_tready) begin
          tvalid_n = 1'b0;
          done_n   = 1'b1;
          state_n  = S_IDLE;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    idle_n = (state_n == S_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (srst) begin
      state         <= S_IDLE;
      x0            <= '0;
      y0            <= '0;
      gc            <= '0;
      gr            <= '0;
      idle_q        <= 1'b1;
      ap_done       <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      cnt_col       <= '0;
      cnt_row       <= '0;
    end else begin
      state         <= state_n;
      x0            <= x0_n;
      y0            <= y0_n;
      gc            <= gc_n;
      gr            <= gr_n;
      idle_q        <= idle_n;
      ap_done       <= done_n;
      m_axis_tvalid <= tvalid_n;
      m_axis_tdata  <= tdata_n;
      m_axis_tuser  <= tuser_n;
      m_axis_tlast  <= tlast_n;
      cnt_col       <= ccol_n;
      cnt_row       <= crow_n;
    end
  end

endmodule

// File: tb/tb_crop_embed.sv
// tb_crop_embed: self-checking bench for crop_embed. A 4x4 frame / 2x2 patch
// instance covers placement, clamping, stalls, reset and back-to-back frames;
// a second 4x4 / 4x4 instance covers the patch-equals-frame case.
module tb_crop_embed;

  localparam int IR = 4;
  localparam int IC = 4;
  localparam int OR = 2;
  localparam int OC = 2;
  localparam int FILL = 0;

  typedef struct packed {
    logic [9:0] data;
    logic       user;
    logic       last;
    logic [1:0] row;
    logic [1:0] col;
  } beat_t;

  logic       clk = 1'b0;
  logic       srst;
  logic       ap_start, ap_ready, ap_idle, ap_done;
  logic [1:0] crop_x0, crop_y0;
  logic       s_tvalid, s_tready;
  logic [9:0] s_tdata;
  logic       m_tvalid, m_tready, m_tuser, m_tlast;
  logic [9:0] m_tdata;
  logic [1:0] cnt_col, cnt_row;

  logic       f_start, f_ready, f_idle, f_done;
  logic       f_s_tvalid, f_s_tready, f_m_tvalid, f_m_tuser, f_m_tlast;
  logic [9:0] f_s_tdata, f_m_tdata;
  logic [1:0] f_cnt_col, f_cnt_row;

  always #5 clk = ~clk;

  crop_embed #(.PIXEL_BIT_WIDTH(10), .IN_ROWS(IR), .IN_COLS(IC),
               .OUT_ROWS(OR), .OUT_COLS(OC), .FILL_VALUE(FILL)) u_dut (
    .clk(clk), .srst(srst), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_idle(ap_idle), .ap_done(ap_done), .crop_x0(crop_x0), .crop_y0(crop_y0),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tuser(m_tuser), .m_axis_tlast(m_tlast),
    .cnt_col(cnt_col), .cnt_row(cnt_row));

  crop_embed #(.PIXEL_BIT_WIDTH(10), .IN_ROWS(4), .IN_COLS(4),
               .OUT_ROWS(4), .OUT_COLS(4), .FILL_VALUE(0)) u_full (
    .clk(clk), .srst(srst), .ap_start(f_start), .ap_ready(f_ready),
    .ap_idle(f_idle), .ap_done(f_done), .crop_x0(2'd0), .crop_y0(2'd0),
    .s_axis_tvalid(f_s_tvalid), .s_axis_tready(f_s_tready), .s_axis_tdata(f_s_tdata),
    .m_axis_tvalid(f_m_tvalid), .m_axis_tready(1'b1), .m_axis_tdata(f_m_tdata),
    .m_axis_tuser(f_m_tuser), .m_axis_tlast(f_m_tlast),
    .cnt_col(f_cnt_col), .cnt_row(f_cnt_row));

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int ph = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int first_valid_cyc = -1;
  int user_cyc = 0;
  int beat_n = 0;
  int st_cyc = 0;
  bit stall = 1'b0;
  bit done_exp = 1'b0;
  bit have_hold = 1'b0;
  logic [16:0] hold_snap;
  beat_t exp_q[$];
  logic [9:0] src_q[$];
  logic [9:0] got_data[64];
  beat_t mon_a, mon_e;

  logic [9:0] p1[4] = '{10'd1, 10'd2, 10'd3, 10'd4};
  logic [9:0] p2[4] = '{10'd5, 10'd6, 10'd7, 10'd8};
  logic [9:0] p3[4] = '{10'd11, 10'd12, 10'd13, 10'd14};
  int exp_a[16] = '{0,0,0,0, 0,0,0,0, 0,1,2,0, 0,3,4,0};
  int exp_c[16] = '{0,0,0,0, 0,0,0,0, 0,0,1,2, 0,0,3,4};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: value of frame pixel (r,c) for a requested origin and a 2x2 patch.
  function automatic int model_pix(input int x, input int y, input logic [9:0] p[4],
                                   input int r, input int c);
    int xc, yc;
    xc = (x > IC - OC) ? IC - OC : x;
    yc = (y > IR - OR) ? IR - OR : y;
    if (r >= yc && r < yc + OR && c >= xc && c < xc + OC)
      return int'(p[(r - yc) * OC + (c - xc)]);
    return FILL;
  endfunction

  function automatic void model_push(input int x, input int y, input logic [9:0] p[4]);
    beat_t b;
    for (int r = 0; r < IR; r++) begin
      for (int c = 0; c < IC; c++) begin
        b.data = 10'(model_pix(x, y, p, r, c));
        b.user = (r == 0 && c == 0);
        b.last = (c == IC - 1);
        b.row  = 2'(r);
        b.col  = 2'(c);
        exp_q.push_back(b);
      end
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Patch source and downstream-ready driver.
  initial begin
    bit s_hs;
    forever begin
      @(negedge clk);
      s_hs = s_tvalid && s_tready && !srst;
      @(posedge clk);
      #1;
      ph++;
      if (s_hs && src_q.size() > 0) void'(src_q.pop_front());
      m_tready = stall ? ph[0] : 1'b1;
      s_tvalid = (src_q.size() > 0) && (!stall || (ph % 3 != 1));
      s_tdata  = (src_q.size() > 0) ? src_q[0] : 10'd0;
    end
  end

  // Compare process: every m_axis handshake, ap_done timing and stall stability.
  always @(negedge clk) begin
    if (srst) begin
      have_hold = 1'b0;
      done_exp  = 1'b0;
    end else begin
      check("ap_done", 32'(ap_done), 32'(done_exp));
      if (ap_done) begin
        done_cnt++;
        done_cyc = cyc;
        check("idle_at_done", 32'(ap_idle), 32'd1);
      end
      if (have_hold)
        check("hold_stable", 32'({m_tvalid, m_tdata, m_tuser, m_tlast, cnt_row, cnt_col}),
              32'(hold_snap));
      done_exp = 1'b0;
      if (m_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (m_tvalid && m_tready) begin
        mon_a = {m_tdata, m_tuser, m_tlast, cnt_row, cnt_col};
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(mon_a), 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat", 32'(mon_a), 32'(mon_e));
          if (mon_e.row == 2'(IR - 1) && mon_e.col == 2'(IC - 1)) done_exp = 1'b1;
        end
        if (m_tuser) user_cyc = cyc;
        if (beat_n < 64) got_data[beat_n] = m_tdata;
        beat_n++;
      end
      have_hold = m_tvalid && !m_tready;
      hold_snap = {m_tvalid, m_tdata, m_tuser, m_tlast, cnt_row, cnt_col};
    end
  end

  task automatic check_reset_vals();
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tdata",  32'(m_tdata),  32'd0);
    check("rst_tuser",  32'(m_tuser),  32'd0);
    check("rst_tlast",  32'(m_tlast),  32'd0);
    check("rst_cnt_col", 32'(cnt_col), 32'd0);
    check("rst_cnt_row", 32'(cnt_row), 32'd0);
    check("rst_s_tready", 32'(s_tready), 32'd0);
    check("rst_ap_done", 32'(ap_done), 32'd0);
    check("rst_ap_ready", 32'(ap_ready), 32'd1);
    check("rst_ap_idle", 32'(ap_idle), 32'd1);
  endtask

  task automatic run_frame(input int x, input int y, input logic [9:0] p[4],
                           input bit stl, input bit pulse, input bit extra);
    int d0, bud;
    @(posedge clk);
    #1;
    stall = stl;
    src_q.delete();
    for (int i = 0; i < 4; i++) src_q.push_back(p[i]);
    if (extra) src_q.push_back(10'd99);
    model_push(x, y, p);
    crop_x0 = 2'(x);
    crop_y0 = 2'(y);
    repeat (2) @(posedge clk);
    #1;
    d0 = done_cnt;
    first_valid_cyc = -1;
    beat_n = 0;
    ap_start = 1'b1;
    @(negedge clk);
    st_cyc = cyc;
    @(posedge clk);
    #1;
    ap_start = 1'b0;
    bud = 0;
    while (done_cnt == d0 && bud < 400) begin
      @(posedge clk);
      #1;
      bud++;
      if (pulse) begin
        ap_start = (bud == 5);
        crop_x0  = (bud == 5) ? 2'd0 : 2'(x);
        crop_y0  = (bud == 5) ? 2'd0 : 2'(y);
      end
    end
    check("frame_done", 32'(done_cnt - d0), 32'd1);
    check("exp_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("idle_after", 32'(ap_idle), 32'd1);
    check("no_restart", 32'(m_tvalid), 32'd0);
    check("single_done", 32'(done_cnt - d0), 32'd1);
    stall = 1'b0;
  endtask

  initial begin
    int d0, d1cyc, bud, fi, fo, f_gap, fd;
    bit f_hs;
    logic [9:0] f_src[16];

    srst = 1'b1; ap_start = 1'b0; crop_x0 = 2'd0; crop_y0 = 2'd0;
    s_tvalid = 1'b0; s_tdata = 10'd0; m_tready = 1'b1;
    f_start = 1'b0; f_s_tvalid = 1'b0; f_s_tdata = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    srst = 1'b0;
    @(negedge clk);
    check_reset_vals();

    // Pin the reference model against hand-computed pixels.
    check("model_r2c1", 32'(model_pix(1, 2, p1, 2, 1)), 32'd1);
    check("model_r3c2", 32'(model_pix(1, 2, p1, 3, 2)), 32'd4);
    check("model_clamp_r3c3", 32'(model_pix(3, 3, p1, 3, 3)), 32'd4);
    check("model_clamp_r1c2", 32'(model_pix(3, 3, p1, 1, 2)), 32'd0);

    // Basic placement, latency, and one surplus patch beat left unconsumed.
    run_frame(1, 2, p1, 1'b0, 1'b0, 1'b1);
    check("first_valid_latency", 32'(first_valid_cyc - st_cyc), 32'd2);
    check("done_latency", 32'(done_cyc - st_cyc), 32'd18);
    check("surplus_left", 32'(src_q.size()), 32'd1);
    for (int i = 0; i < 16; i++) check("t1_data", 32'(got_data[i]), 32'(exp_a[i]));

    // Same frame with both-side stalls and a stray ap_start mid-frame.
    run_frame(1, 2, p1, 1'b1, 1'b1, 1'b0);
    check("stall_beats", 32'(beat_n), 32'd16);
    for (int i = 0; i < 16; i++) check("stall_data", 32'(got_data[i]), 32'(exp_a[i]));

    // Origin past the limit clamps to (2,2).
    run_frame(3, 3, p1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) check("clamp_data", 32'(got_data[i]), 32'(exp_c[i]));

    // Reset mid-frame drops the frame with no ap_done.
    @(posedge clk);
    #1;
    src_q.delete();
    for (int i = 0; i < 4; i++) src_q.push_back(p2[i]);
    model_push(0, 0, p2);
    crop_x0 = 2'd0; crop_y0 = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    d0 = done_cnt;
    beat_n = 0;
    ap_start = 1'b1;
    @(posedge clk);
    #1;
    ap_start = 1'b0;
    bud = 0;
    while (beat_n < 7 && bud < 100) begin
      @(posedge clk);
      #1;
      bud++;
    end
    check("reached_beat7", 32'(beat_n >= 7), 32'd1);
    srst = 1'b1;
    @(posedge clk);
    #1;
    srst = 1'b0;
    exp_q.delete();
    src_q.delete();
    @(negedge clk);
    check_reset_vals();
    repeat (10) @(posedge clk);
    #1;
    check("no_done_after_srst", 32'(done_cnt - d0), 32'd0);
    run_frame(0, 0, p2, 1'b0, 1'b0, 1'b0);

    // ap_start held high: two back-to-back frames.
    @(posedge clk);
    #1;
    src_q.delete();
    for (int i = 0; i < 4; i++) src_q.push_back(p1[i]);
    for (int i = 0; i < 4; i++) src_q.push_back(p3[i]);
    model_push(1, 2, p1);
    model_push(1, 2, p3);
    crop_x0 = 2'd1; crop_y0 = 2'd2;
    repeat (2) @(posedge clk);
    #1;
    d0 = done_cnt;
    ap_start = 1'b1;
    bud = 0;
    while (done_cnt < d0 + 1 && bud < 400) begin
      @(posedge clk);
      #1;
      bud++;
    end
    d1cyc = done_cyc;
    ap_start = 1'b0;
    bud = 0;
    while (done_cnt < d0 + 2 && bud < 400) begin
      @(posedge clk);
      #1;
      bud++;
    end
    check("two_frames", 32'(done_cnt - d0), 32'd2);
    check("back_to_back_start", 32'(user_cyc - d1cyc), 32'd2);
    check("held_exp_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // Patch equals frame: pass-through, no source backpressure.
    for (int i = 0; i < 16; i++) f_src[i] = 10'(i * 7 + 3);
    @(posedge clk);
    #1;
    fi = 0; fo = 0; f_gap = 0; fd = 0;
    f_s_tvalid = 1'b1;
    f_s_tdata  = f_src[0];
    f_start    = 1'b1;
    @(posedge clk);
    #1;
    f_start = 1'b0;
    bud = 0;
    while (fo < 16 && bud < 200) begin
      @(negedge clk);
      bud++;
      f_hs = f_s_tvalid && f_s_tready;
      if (!f_idle && fi < 16 && !f_s_tready) f_gap++;
      if (f_m_tvalid) begin
        if (fo < 16) check("full_data", 32'(f_m_tdata), 32'(f_src[fo]));
        fo++;
      end
      @(posedge clk);
      #1;
      if (f_hs) fi++;
      f_s_tvalid = (fi < 16);
      f_s_tdata  = (fi < 16) ? f_src[fi] : 10'd0;
    end
    check("full_beats", 32'(fo), 32'd16);
    check("full_tready_gaps", 32'(f_gap), 32'd0);
    repeat (3) begin
      @(negedge clk);
      if (f_done) fd++;
    end
    check("full_done_once", 32'(fd), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/crop_embed.md
Name: crop_embed

Overview:
- Inverse of the crop/normalize path. Accepts a cropped patch stream of OUT_ROWS x OUT_COLS pixels in raster order.
- Emits a full IN_ROWS x IN_COLS raster frame with the patch placed at (crop_x0, crop_y0) and FILL_VALUE everywhere else.
- Sits downstream of the patch-processing stage. Produces full-frame pixels plus the row/column counters that frame-level consumers use.
- Controlled per frame by the ap_start/ap_done/ap_ready/ap_idle handshake.

Parameters:
- PIXEL_BIT_WIDTH, 10, pixel width in bits.
- IN_ROWS, 20, output frame rows.
- IN_COLS, 20, output frame columns.
- OUT_ROWS, 10, patch rows (must be <= IN_ROWS).
- OUT_COLS, 10, patch columns (must be <= IN_COLS).
- FILL_VALUE, 0, pixel value emitted outside the patch window.

Ports:
- clk  in  1  single clock.
- srst  in  1  synchronous active-high reset.
- ap_start  in  1  start one frame; sampled only when ap_ready=1.
- ap_ready  out  1  high in IDLE; block can accept ap_start.
- ap_idle  out  1  high in IDLE.
- ap_done  out  1  one-cycle pulse after the last frame pixel handshakes.
- crop_x0  in  $clog2(IN_COLS)  patch left column; latched at start.
- crop_y0  in  $clog2(IN_ROWS)  patch top row; latched at start.
- s_axis_tvalid  in  1  patch pixel valid.
- s_axis_tready  out  1  patch pixel accepted.
- s_axis_tdata  in  PIXEL_BIT_WIDTH  patch pixel.
- m_axis_tvalid  out  1  frame pixel valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  PIXEL_BIT_WIDTH  frame pixel.
- m_axis_tuser  out  1  high on the first pixel of the frame, (row 0, col 0).
- m_axis_tlast  out  1  high on the last pixel of each row.
- cnt_col  out  $clog2(IN_COLS)  column of the pixel currently on m_axis.
- cnt_row  out  $clog2(IN_ROWS)  row of the pixel currently on m_axis.

Behaviour:
- State machine: IDLE, RUN, DRAIN.
- Reset (srst=1, any state, including mid-frame):
  - State goes to IDLE; row/col generation counters and output register clear.
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, cnt_col=0, cnt_row=0.
  - s_axis_tready=0, ap_done=0, ap_ready=1, ap_idle=1.
  - A partial frame is dropped; no ap_done is issued for it.
- IDLE:
  - ap_ready=ap_idle=1; s_axis_tready=0.
  - ap_start=1 latches crop_x0/crop_y0 and moves to RUN next cycle.
  - Clamping at latch: x0 = min(crop_x0, IN_COLS-OUT_COLS); y0 = min(crop_y0, IN_ROWS-OUT_ROWS). The patch therefore never wraps or truncates.
- RUN:
  - ap_ready=ap_idle=0; ap_start is ignored.
  - Generation counters (gr, gc) walk the frame in raster order starting at (0,0).
  - Single output register; load_en = !m_axis_tvalid || m_axis_tready.
  - Inside window means x0 <= gc < x0+OUT_COLS and y0 <= gr < y0+OUT_ROWS.
  - When inside: s_axis_tready = load_en. On s_axis handshake, load s_axis_tdata and advance the counters. If s_axis_tvalid=0, hold and stall with no bubble-filling.
  - When outside: s_axis_tready=0. When load_en=1, load FILL_VALUE and advance the counters.
  - Each load also registers tuser = (gr==0 && gc==0), tlast = (gc==IN_COLS-1), cnt_row=gr, cnt_col=gc.
  - Column wraps at IN_COLS-1 to 0 and increments the row.
  - Loading (IN_ROWS-1, IN_COLS-1) moves the state to DRAIN.
- DRAIN:
  - s_axis_tready=0; no new loads.
  - When the m_axis handshake completes (tvalid && tready): tvalid drops to 0, ap_done=1 for the next cycle, and state returns to IDLE.
- Latency:
  - ap_start at cycle T gives RUN at T+1; first m_axis_tvalid at T+2 when pixel (0,0) is outside the window or the patch is already valid.
  - Throughput is 1 pixel/cycle with no stalls, so an unstalled frame has ap_done at T+2+IN_ROWS*IN_COLS.
- Ordering and counts:
  - m_axis output is held stable while tvalid && !tready.
  - The block accepts exactly OUT_ROWS*OUT_COLS patch beats per frame. Extra beats are not consumed (s_axis_tready stays 0), and backpressure passes through to the patch source.
- Simultaneous events: srst has priority over ap_start and over any handshake. ap_start and srst in the same cycle leave the block in IDLE.
- Width rules: window compares are done at $clog2(max(IN))+1 bits to avoid overflow of x0+OUT_COLS.

Test Plan:
- IN 4x4, OUT 2x2, FILL 0, x0=1, y0=2, patch 1,2,3,4, no stalls -> 16 beats: rows 0-1 all 0; row2 = 0,1,2,0; row3 = 0,3,4,0. tuser on beat 0 only; tlast on beats 3,7,11,15; ap_done 1 cycle after beat 15.
- Same setup with m_axis_tready toggling 1/0 and s_axis_tvalid gaps inside the window -> identical data sequence; tdata/tuser/tlast/cnt held stable during stalls; no duplicated or skipped beats.
- crop_x0=3, crop_y0=3 with 4x4/2x2 -> clamped to (2,2); patch occupies rows 2-3, cols 2-3.
- OUT=IN=4x4, x0=y0=0 -> output equals the 16 input pixels exactly; s_axis_tready never low while m_axis_tready=1.
- srst asserted after beat 6 -> all outputs return to reset values the next cycle. New ap_start produces a complete correct frame, and only one ap_done is seen.
- ap_start held high through two frames -> second frame starts the cycle after ap_done (IDLE then RUN). ap_start pulses during RUN have no effect.
